// File: rtl/ring_seq_pkg.sv
// rtl/ring_seq_pkg.sv - shared types, pin map and rate table for the walking-bit sequencer
package ring_seq_pkg;

  localparam int WIDTH_DEF      = 6;
  localparam int PRESCALE_W_DEF = 11;
  localparam int POS_W          = 3;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } seq_state_e;

  localparam logic [PRESCALE_W_DEF-1:0] RATE_LIM_0 = 11'd0;
  localparam logic [PRESCALE_W_DEF-1:0] RATE_LIM_1 = 11'd15;
  localparam logic [PRESCALE_W_DEF-1:0] RATE_LIM_2 = 11'd255;
  localparam logic [PRESCALE_W_DEF-1:0] RATE_LIM_3 = 11'd2047;

  localparam int PIN_CLK     = 0;
  localparam int PIN_RST     = 1;
  localparam int PIN_MODE    = 2;
  localparam int PIN_RATE_LO = 3;
  localparam int PIN_RATE_HI = 4;
  localparam int PIN_PAUSE   = 5;
  localparam int PIN_DIR     = 6;
  localparam int PIN_STEP    = 7;

  localparam int OUT_STROBE  = 6;
  localparam int OUT_DIR     = 7;

  function automatic logic [PRESCALE_W_DEF-1:0] rate_limit(input logic [1:0] code);
    case (code)
      2'd0:    return RATE_LIM_0;
      2'd1:    return RATE_LIM_1;
      2'd2:    return RATE_LIM_2;
      default: return RATE_LIM_3;
    endcase
  endfunction

endpackage

// File: rtl/ring_prescaler.sv
// rtl/ring_prescaler.sv - step-rate divider producing a one-cycle tick at the selected divisor
module ring_prescaler
  import ring_seq_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_rate,
  input  logic       i_hold,
  output logic       o_tick
);

  logic [PRESCALE_W-1:0] r_count;
  logic [1:0]            r_rate_q;
  logic [PRESCALE_W-1:0] w_limit;
  logic                  w_rate_chg;
  logic                  w_term;

  assign w_limit    = PRESCALE_W'(rate_limit(i_rate));
  assign w_rate_chg = (i_rate != r_rate_q);
  assign w_term     = (r_count == w_limit);
  // A rate change restarts the count so the counter never sits above the new limit.
  assign o_tick     = w_term & ~i_hold & ~w_rate_chg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count  <= '0;
      r_rate_q <= '0;
    end else begin
      r_rate_q <= i_rate;
      if (i_hold || w_rate_chg || w_term) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/ring_sequencer_ctrl.sv
// rtl/ring_sequencer_ctrl.sv - one-hot lamp sequencer: input sync, RUN/HOLD FSM, rotate/ping-pong motion
module ring_sequencer_ctrl
  import ring_seq_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int SYNC_MODE    = PIN_MODE - PIN_MODE;
  localparam int SYNC_RATE_LO = PIN_RATE_LO - PIN_MODE;
  localparam int SYNC_RATE_HI = PIN_RATE_HI - PIN_MODE;
  localparam int SYNC_PAUSE   = PIN_PAUSE - PIN_MODE;
  localparam int SYNC_DIR     = PIN_DIR - PIN_MODE;
  localparam int SYNC_STEP    = PIN_STEP - PIN_MODE;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIDTH - 1);

  logic                w_clk;
  logic                w_rst;
  logic [5:0]          r_meta;
  logic                r_mode_s;
  logic [1:0]          r_rate_s;
  logic                r_dir_s;
  logic                r_step_s;
  logic                r_step_d;
  seq_state_e          r_state;
  seq_state_e          w_state_nxt;
  logic                w_hold;
  logic                w_adv;
  logic                w_tick;
  logic                w_step_edge;
  logic [POS_W-1:0]    r_pos;
  logic [POS_W-1:0]    w_pos_nxt;
  logic                r_dir;
  logic                w_dir_nxt;
  logic                r_strobe;
  logic [WIDTH-1:0]    r_pattern;

  assign w_clk       = io_in[PIN_CLK];
  assign w_rst       = io_in[PIN_RST];
  assign w_step_edge = r_step_s & ~r_step_d;

  // Pause's second synchronizer stage is the FSM state register itself.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_meta   <= '0;
      r_mode_s <= 1'b0;
      r_rate_s <= '0;
      r_dir_s  <= 1'b0;
      r_step_s <= 1'b0;
      r_step_d <= 1'b0;
    end else begin
      r_meta   <= io_in[PIN_STEP:PIN_MODE];
      r_mode_s <= r_meta[SYNC_MODE];
      r_rate_s <= r_meta[SYNC_RATE_HI:SYNC_RATE_LO];
      r_dir_s  <= r_meta[SYNC_DIR];
      r_step_s <= r_meta[SYNC_STEP];
      r_step_d <= r_step_s;
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_meta[SYNC_PAUSE] ? ST_HOLD : ST_RUN;
  end

  always_comb begin
    w_hold = 1'b0;
    w_adv  = 1'b0;
    case (r_state)
      ST_RUN:  w_adv = w_tick;
      ST_HOLD: begin
        w_hold = 1'b1;
        w_adv  = w_step_edge;
      end
      default: w_adv = 1'b0;
    endcase
  end

  ring_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .i_clk (w_clk),
    .i_rst (w_rst),
    .i_rate(r_rate_s),
    .i_hold(w_hold),
    .o_tick(w_tick)
  );

  always_comb begin
    w_pos_nxt = r_pos;
    w_dir_nxt = r_dir;
    if (!r_mode_s) begin
      w_dir_nxt = r_dir_s;
      if (w_adv) begin
        if (r_dir_s) begin
          w_pos_nxt = (r_pos == '0) ? POS_LAST : r_pos - POS_W'(1);
        end else begin
          w_pos_nxt = (r_pos == POS_LAST) ? '0 : r_pos + POS_W'(1);
        end
      end
    end else if (w_adv) begin
      // Ping-pong bounces off either end, flipping direction on the same edge.
      if (!r_dir && r_pos == POS_LAST) begin
        w_pos_nxt = POS_LAST - POS_W'(1);
        w_dir_nxt = 1'b1;
      end else if (r_dir && r_pos == '0) begin
        w_pos_nxt = POS_W'(1);
        w_dir_nxt = 1'b0;
      end else if (r_dir) begin
        w_pos_nxt = r_pos - POS_W'(1);
      end else begin
        w_pos_nxt = r_pos + POS_W'(1);
      end
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_pos     <= '0;
      r_dir     <= 1'b0;
      r_strobe  <= 1'b0;
      r_pattern <= WIDTH'(1);
    end else begin
      r_pos     <= w_pos_nxt;
      r_dir     <= w_dir_nxt;
      r_strobe  <= w_adv;
      r_pattern <= WIDTH'(1) << w_pos_nxt;
    end
  end

  assign io_out[WIDTH-1:0]  = r_pattern;
  assign io_out[OUT_STROBE] = r_strobe;
  assign io_out[OUT_DIR]    = r_dir;

endmodule

// File: doc/ring_sequencer_ctrl.md
# ring_sequencer_ctrl

Control sequencer for the 6-lamp walking-bit display used across our Tiny Tapeout designs. It owns a one-hot 6-bit pattern register and a programmable prescaler that sets the step rate. It supports rotate and ping-pong motion, pause with single-step, and a step strobe output. The block replaces the ad-hoc load/shift mux plus ripple divider with one synchronous controller driven from the standard 8-in/8-out user pin bus.

## Interface
Parameters:
- WIDTH, 6 — lamp count / pattern width; position register is 3 bits.
- PRESCALE_W, 11 — prescaler counter width; the largest divisor is 2^PRESCALE_W.

Ports (io_in / io_out, 8 bits each):
- io_in[0]  input  1  clk; one clock; all state is on the rising edge.
- io_in[1]  input  1  rst; reset is synchronous and active-high; it is not synchronized.
- io_in[2]  input  1  mode: 0 = rotate, 1 = ping-pong.
- io_in[4:3]  input  2  rate select: 0→÷1, 1→÷16, 2→÷256, 3→÷2048.
- io_in[5]  input  1  pause: 1 = HOLD.
- io_in[6]  input  1  dir in rotate mode: 0 = forward (bit i→i+1), 1 = reverse.
- io_in[7]  input  1  step: a rising edge advances one position while in HOLD.
- io_out[5:0]  output  6  lamp pattern, one-hot, registered.
- io_out[6]  output  1  step strobe: high for 1 cycle on the cycle after each advance.
- io_out[7]  output  1  current direction, registered; 1 = reverse.

## Operation
- Control inputs io_in[7:2] pass through 2-flop synchronizers, giving 2 cycles of latency. Step edge detection uses a third flop on the synchronized step signal.
- Internal state:
  - pos (0..5)
  - dir_q
  - prescaler count c
  - FSM state RUN / HOLD
- Pattern output = 1 << pos. Exactly one bit is set at all times, including during and after reset.
- RUN: c increments each cycle. When c == N−1 (N = selected divisor), c→0 and an advance occurs on that edge. For N = 1 the block advances every cycle.
- HOLD is entered when synchronized pause = 1:
  - c is held at 0.
  - A synchronized step rising edge advances exactly once.
  - Step edges in RUN are ignored.
- HOLD→RUN: c restarts from 0, so the first advance occurs N cycles after pause deasserts (plus synchronizer latency).
- A change of synchronized rate clears c to 0 on that cycle. No advance occurs on that cycle.
- Rotate advance:
  - Forward: pos = (pos == 5) ? 0 : pos+1.
  - Reverse: pos = (pos == 0) ? 5 : pos−1.
  - dir_q follows synchronized io_in[6] every cycle.
- Ping-pong advance: io_in[6] is ignored.
  - pos = 5 with forward: pos→4 and dir_q→1 on the same edge.
  - pos = 0 with reverse: pos→1 and dir_q→0 on the same edge.
  - Otherwise pos moves one step in dir_q.
- Switching ping-pong→rotate: dir_q loads synchronized io_in[6] on the next cycle. pos is unchanged.
- Switching rotate→ping-pong: motion continues from the current pos and dir_q.

## Timing
- Reset values:
  - io_out[5:0] = 000001
  - io_out[6] = 0
  - io_out[7] = 0
  - pos = 0, c = 0, FSM = RUN
  - all synchronizer and edge flops = 0
- Reset has priority over every event, including a pending tick or step edge. Asserting rst mid-run returns all state to reset values on that edge.
- Pattern latency: pos updates on the advance edge and io_out[5:0] reflects it immediately after. io_out[6] rises on that same edge and falls on the next.
- Pause and prescaler terminal count in the same cycle: pause wins, no advance, c→0.
- The prescaler never exceeds N−1; rate 3 uses the full 11-bit range (0..2047).

## Structure
- Package ring_seq_pkg holds:
  - state enum {RUN, HOLD}
  - rate-code → divisor-minus-one constants (0, 15, 255, 2047)
  - WIDTH default
  - the pin-index localparams for io_in and io_out
- One sub-module, ring_prescaler:
  - inputs: clk, rst, rate code, hold
  - output: 1-cycle tick
  - internal c and rate-change clear
- The top contains the synchronizers, FSM, pos/dir logic and output registers.

## Test plan
- Reset, mode = 0, rate = 0, dir = 0: pattern walks 000001→000010→…→100000→000001 on consecutive cycles. Strobe is high every cycle and io_out[7] = 0.
- Rate = 1: successive pattern changes are exactly 16 cycles apart. Strobe pulses are 1 cycle wide. Switching to rate = 2 mid-count gives the next advance 256 cycles after the synchronized change.
- Mode = 1, rate = 0:
  - sequence is 000001,000010,000100,001000,010000,100000,010000,…
  - io_out[7] becomes 1 together with the first 010000 after 100000.
  - io_out[7] returns to 0 together with 000010 after 000001.
- Pause = 1: pattern is frozen for 200 cycles. Three step pulses, each 4 cycles high / 4 cycles low, advance exactly 3 positions. Step pulses with pause = 0 cause no extra advance.
- Mode = 0, dir = 1 from reset: 000001→100000→010000, io_out[7] = 1.
- Rate = 3 run of ~1000 cycles, then rst for 1 cycle: the next output is 000001 with strobe 0. The first advance occurs 2048 cycles after reset release.
